// File: rtl/pipes_pkg.sv
// Shared types for the front-end pipeline: machine word, instruction word,
// fetch FSM states and the default reset PC.
`timescale 1ns/1ps
package pipes_pkg;

  typedef logic [63:0] word_t;
  typedef logic [31:0] instr_t;

  localparam word_t PC_RESET_DEFAULT = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; the low two target bits carry no meaning.
  function automatic word_t align_pc(input word_t pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding request, a one-entry skid buffer
// for decode back-pressure, and discard of wrong-path responses after a redirect.
`timescale 1ns/1ps
module fetch
  import pipes_pkg::*;
#(
  parameter word_t PC_RESET = PC_RESET_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_pc,
  input  logic         stall,
  output logic         ireq_valid,
  output logic [63:0]  ireq_addr,
  input  logic         iresp_data_ok,
  input  logic [31:0]  iresp_data,
  output logic         out_valid,
  output logic [63:0]  out_pc,
  output logic [31:0]  out_instr
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        req_addr_q, req_addr_d;
  word_t        skid_pc_q, skid_pc_d;
  instr_t       skid_instr_q, skid_instr_d;
  word_t        out_pc_q, out_pc_d;
  instr_t       out_instr_q, out_instr_d;
  logic         out_valid_q, out_valid_d;

  logic         slot_free;
  word_t        pc_inc;
  word_t        redirect_tgt;

  assign slot_free    = !out_valid_q || !stall;
  assign pc_inc       = pc_q + 64'd4;
  assign redirect_tgt = align_pc(redirect_pc);

  // The request is withheld while reset is held so nothing issues before release.
  assign ireq_valid = reset && (state_q != ST_HOLD);
  assign ireq_addr  = req_addr_q;
  assign out_valid  = out_valid_q;
  assign out_pc     = out_pc_q;
  assign out_instr  = out_instr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_addr_d   = req_addr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    out_valid_d  = out_valid_q;

    if (redirect_valid) begin
      out_valid_d = 1'b0;
      pc_d        = redirect_tgt;
      case (state_q)
        ST_FETCH: begin
          // An unanswered request cannot be retracted, so its answer is drained.
          if (iresp_data_ok) req_addr_d = redirect_tgt;
          else               state_d    = ST_DRAIN;
        end
        ST_HOLD: begin
          req_addr_d = redirect_tgt;
          state_d    = ST_FETCH;
        end
        ST_DRAIN: begin
          if (iresp_data_ok) begin
            req_addr_d = redirect_tgt;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (iresp_data_ok) begin
            if (slot_free) begin
              out_pc_d    = req_addr_q;
              out_instr_d = iresp_data;
              out_valid_d = 1'b1;
              pc_d        = pc_inc;
              req_addr_d  = pc_inc;
            end else begin
              skid_pc_d    = req_addr_q;
              skid_instr_d = iresp_data;
              state_d      = ST_HOLD;
            end
          end else if (slot_free) begin
            out_valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            out_pc_d    = skid_pc_q;
            out_instr_d = skid_instr_q;
            out_valid_d = 1'b1;
            pc_d        = pc_inc;
            req_addr_d  = pc_inc;
            state_d     = ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (slot_free) out_valid_d = 1'b0;
          if (iresp_data_ok) begin
            req_addr_d = pc_q;
            state_d    = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= PC_RESET;
      req_addr_q   <= PC_RESET;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      out_pc_q     <= '0;
      out_instr_q  <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for the fetch stage: directed scenarios followed by randomized
// traffic checked against an in-order instruction-stream model.
`timescale 1ns/1ps
module tb_fetch;

  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int total = 0;
  int bad   = 0;

  // Model state for the random phase.
  logic [63:0] exp_pc;
  int          delivered;
  logic        p_redirect, p_stall, p_out_valid, p_ireq_valid, p_data_ok;
  logic [63:0] p_out_pc, p_ireq_addr;
  logic [31:0] p_out_instr;

  fetch #(.PC_RESET(PC_RST)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .ireq_valid     (ireq_valid),
    .ireq_addr      (ireq_addr),
    .iresp_data_ok  (iresp_data_ok),
    .iresp_data     (iresp_data),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr)
  );

  always #5 clk = ~clk;

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] memf(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  assign iresp_data = memf(ireq_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    iresp_data_ok  = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_ireq_valid", 64'(ireq_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_ireq_valid", 64'(ireq_valid), 64'd1);
    check("rel_ireq_addr", ireq_addr, PC_RST);

    // Back-to-back fetch with zero-wait memory
    iresp_data_ok = 1'b1;
    tick();
    check("seq0_valid", 64'(out_valid), 64'd1);
    check("seq0_pc", out_pc, 64'h8000_0000);
    check("seq0_instr", 64'(out_instr), 64'(memf(64'h8000_0000)));
    check("seq0_addr", ireq_addr, 64'h8000_0004);
    tick();
    check("seq1_pc", out_pc, 64'h8000_0004);
    tick();
    check("seq2_pc", out_pc, 64'h8000_0008);
    check("seq2_addr", ireq_addr, 64'h8000_000C);

    // Stall with no data, then data arrives under stall
    stall = 1'b1;
    iresp_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pc", out_pc, 64'h8000_0008);
      check("stall_hold_valid", 64'(out_valid), 64'd1);
      check("stall_req_addr", ireq_addr, 64'h8000_000C);
      check("stall_req_valid", 64'(ireq_valid), 64'd1);
    end
    iresp_data_ok = 1'b1;
    tick();
    check("hold_ireq_valid", 64'(ireq_valid), 64'd0);
    check("hold_out_pc", out_pc, 64'h8000_0008);
    check("hold_out_instr", 64'(out_instr), 64'(memf(64'h8000_0008)));
    iresp_data_ok = 1'b0;
    stall = 1'b0;
    tick();
    check("skid_pc", out_pc, 64'h8000_000C);
    check("skid_instr", 64'(out_instr), 64'(memf(64'h8000_000C)));
    check("skid_valid", 64'(out_valid), 64'd1);
    check("skid_next_addr", ireq_addr, 64'h8000_0010);
    check("skid_next_valid", 64'(ireq_valid), 64'd1);

    // Redirect while a request is outstanding; its answer must be drained
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    check("drain0_valid", 64'(out_valid), 64'd0);
    check("drain0_addr", ireq_addr, 64'h8000_0010);
    check("drain0_req", 64'(ireq_valid), 64'd1);
    tick();
    check("drain1_valid", 64'(out_valid), 64'd0);
    check("drain1_addr", ireq_addr, 64'h8000_0010);
    iresp_data_ok = 1'b1;
    tick();
    check("drain2_valid", 64'(out_valid), 64'd0);
    check("drain2_addr", ireq_addr, 64'h8000_0100);
    tick();
    check("tgt_pc", out_pc, 64'h8000_0100);
    check("tgt_instr", 64'(out_instr), 64'(memf(64'h8000_0100)));
    check("tgt_next_addr", ireq_addr, 64'h8000_0104);

    // Redirect coinciding with data_ok, unaligned target
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0203;
    tick();
    redirect_valid = 1'b0;
    check("same_valid", 64'(out_valid), 64'd0);
    check("same_addr", ireq_addr, 64'h8000_0200);
    tick();
    check("same_out_pc", out_pc, 64'h8000_0200);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check("wrap_req", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    check("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_next_addr", ireq_addr, 64'd0);
    tick();
    check("wrap_zero_pc", out_pc, 64'd0);

    // Reset asserted while holding a skid entry
    stall = 1'b1;
    tick();
    check("hold2_ireq_valid", 64'(ireq_valid), 64'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_ireq", 64'(ireq_valid), 64'd0);
    check("mid_rst_instr", 64'(out_instr), 64'd0);
    stall = 1'b0;
    tick();
    check("rst_resp_ignored", 64'(out_valid), 64'd0);
    iresp_data_ok = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rerel_ireq_valid", 64'(ireq_valid), 64'd1);
    check("rerel_addr", ireq_addr, PC_RST);
    check("rerel_out_valid", 64'(out_valid), 64'd0);
    iresp_data_ok = 1'b1;
    tick();
    check("rerel_out_pc", out_pc, PC_RST);

    // Randomized traffic against the in-order stream model
    rst_n = 1'b0;
    iresp_data_ok = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    exp_pc = PC_RST;
    delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        redirect_pc = {32'hFFFF_FFFF, 24'hFF_FFFF, 8'($urandom_range(0, 255))};
      else
        redirect_pc = {$urandom(), $urandom()};
      iresp_data_ok = ireq_valid && ($urandom_range(0, 9) < 7);

      if (redirect_valid) begin
        exp_pc = {redirect_pc[63:2], 2'b00};
      end else if (out_valid && !stall) begin
        check("rnd_pc", out_pc, exp_pc);
        check("rnd_instr", 64'(out_instr), 64'(memf(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end

      p_redirect   = redirect_valid;
      p_stall      = stall;
      p_out_valid  = out_valid;
      p_out_pc     = out_pc;
      p_out_instr  = out_instr;
      p_ireq_valid = ireq_valid;
      p_ireq_addr  = ireq_addr;
      p_data_ok    = iresp_data_ok;
      tick();

      if (p_redirect) begin
        check("rnd_flush", 64'(out_valid), 64'd0);
      end else if (p_out_valid && p_stall) begin
        check("rnd_hold_valid", 64'(out_valid), 64'd1);
        check("rnd_hold_pc", out_pc, p_out_pc);
        check("rnd_hold_instr", 64'(out_instr), 64'(p_out_instr));
      end
      if (p_ireq_valid && !p_data_ok) begin
        check("rnd_req_valid", 64'(ireq_valid), 64'd1);
        check("rnd_req_stable", ireq_addr, p_ireq_addr);
      end
    end
    redirect_valid = 1'b0;
    iresp_data_ok  = 1'b0;
    check("rnd_progress", 64'(delivered >= 500), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter PC_RESET, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-004 redirect_valid  in  1  branch-taken pulse from execute (branch_enable), one cycle per redirect.
REQ-005 redirect_pc  in  64 (word_t)  redirect target; bits [1:0] ignored, forced to 0.
REQ-006 stall  in  1  downstream (decode) cannot accept out_* this cycle.
REQ-007 ireq_valid  out  1  instruction-memory request valid.
REQ-008 ireq_addr  out  64  request address.
REQ-009 iresp_data_ok  in  1  response for outstanding request valid this cycle.
REQ-010 iresp_data  in  32  fetched instruction, valid with iresp_data_ok.
REQ-011 out_valid  out  1  out_pc/out_instr hold a valid instruction for decode.
REQ-012 out_pc  out  64  PC of delivered instruction.
REQ-013 out_instr  out  32  delivered instruction.

Function
REQ-014 States SHALL be FETCH (request outstanding), HOLD (response buffered, output slot busy), DRAIN (discarding a wrong-path response).
REQ-015 Registers SHALL be pc (next fetch), req_addr (outstanding address), skid_instr/skid_pc, out_pc/out_instr/out_valid, state.
REQ-016 ireq_addr SHALL equal req_addr; ireq_valid SHALL be 1 in FETCH and DRAIN, 0 in HOLD; ireq_addr SHALL stay stable from assertion until the data_ok cycle.
REQ-017 Output slot is free when out_valid==0 or stall==0; out_* SHALL not change while out_valid==1 and stall==1 except on redirect.
REQ-018 FETCH, data_ok, slot free, no redirect: load out_* with (req_addr, iresp_data), out_valid=1, pc and req_addr = pc+4, stay FETCH (new request next cycle).
REQ-019 FETCH, data_ok, slot busy, no redirect: load skid_*, go HOLD.
REQ-020 HOLD, stall==0, no redirect: move skid_* to out_*, pc and req_addr = pc+4, go FETCH.
REQ-021 Slot free with no data: out_valid SHALL drop to 0 next cycle.
REQ-022 Redirect has priority over all events; out_valid SHALL be 0 next cycle regardless of stall; pc = {redirect_pc[63:2],2'b00}.
REQ-023 Redirect in FETCH with data_ok same cycle: discard data, req_addr=target, stay FETCH.
REQ-024 Redirect in FETCH without data_ok: keep req_addr, go DRAIN.
REQ-025 Redirect in HOLD: discard skid, req_addr=target, go FETCH.
REQ-026 DRAIN: on data_ok discard response, req_addr=pc, go FETCH; redirect in DRAIN updates pc only, stay DRAIN (or FETCH if data_ok same cycle).
REQ-027 pc+4 SHALL wrap modulo 2^64.
REQ-028 Zero-wait memory: one instruction per cycle sustained when stall==0.

Reset
REQ-029 During reset: state=FETCH, pc=req_addr=PC_RESET, out_valid=0, out_pc=0, out_instr=0, skid_*=0, ireq_valid=0.
REQ-030 After reset release, ireq_valid=1 with ireq_addr=PC_RESET first cycle; reset mid-request abandons it, response before first new request ignored.

Structure
REQ-031 fetch_state_t enum and PC_RESET default constant SHALL reside in the shared pipes package.
REQ-032 Single module, no sub-modules.

Verification
REQ-033 Reset release, data_ok every cycle, stall=0 -> out_pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles.
REQ-034 out_valid=1, stall=1 for 3 cycles, data_ok arrives -> state HOLD, ireq_valid=0, out_* unchanged; stall drops -> skid instruction delivered next cycle.
REQ-035 Request 0x80000010 outstanding, redirect to 0x80000100, data_ok 2 cycles later -> response discarded, next ireq_addr 0x80000100, out_valid 0 meanwhile.
REQ-036 Redirect to 0x80000203 same cycle as data_ok -> data discarded, next ireq_addr 0x80000200.
REQ-037 pc=64'hFFFF_FFFF_FFFF_FFFC fetched -> next ireq_addr 0.
REQ-038 reset asserted mid-HOLD -> out_valid 0 immediately, ireq_addr PC_RESET after release.
